// File: rtl/alu_sequencer.sv
// Command-driven sequencer that drives the 16-bit ALU's operand-load strobes on the
// shared num bus and returns the captured ALU result through a valid/ready response.
module alu_sequencer #(
    parameter int WIDTH  = 16,
    parameter int OPW    = 3,
    parameter int MAX_OP = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_keep_b,
    output logic [WIDTH-1:0] alu_num,
    output logic             alu_en1,
    output logic             alu_en2,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_out_en,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [OPW-1:0] MAX_OP_C = MAX_OP[OPW-1:0];

    state_t           state;
    state_t           next_state;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             keep_q;
    logic             b_loaded;
    logic             ready_q;
    logic             accept;
    logic             illegal;

    // ready_q keeps cmd_ready low through the reset cycle, so acceptance follows it too
    assign accept  = (state == S_IDLE) && ready_q && cmd_valid;
    assign illegal = (cmd_op > MAX_OP_C);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = illegal ? S_RESP : S_LOAD_A;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_LOAD_A: begin
                if (keep_q && b_loaded) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_LOAD_B;
                end
            end
            S_LOAD_B: next_state = S_EXEC;
            S_EXEC:   next_state = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_RESP;
                end
            end
            default:  next_state = S_IDLE;
        endcase
    end

    // Command latch, B-operand tracking and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= {OPW{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            keep_q   <= 1'b0;
            b_loaded <= 1'b0;
            ready_q  <= 1'b0;
            rsp_data <= {WIDTH{1'b0}};
            rsp_err  <= 1'b0;
        end else begin
            ready_q <= (next_state == S_IDLE);
            if (accept) begin
                op_q   <= cmd_op;
                a_q    <= cmd_a;
                b_q    <= cmd_b;
                keep_q <= cmd_keep_b;
                if (illegal) begin
                    rsp_data <= {WIDTH{1'b0}};
                    rsp_err  <= 1'b1;
                end
            end
            if (state == S_LOAD_B) begin
                b_loaded <= 1'b1;
            end
            if (state == S_EXEC) begin
                rsp_data <= alu_result;
                rsp_err  <= 1'b0;
            end
        end
    end

    // Output decode from the state register
    always_comb begin
        alu_num    = {WIDTH{1'b0}};
        alu_en1    = 1'b0;
        alu_en2    = 1'b0;
        alu_op     = {OPW{1'b0}};
        alu_out_en = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_LOAD_A: begin
                alu_num = a_q;
                alu_en1 = 1'b1;
                alu_op  = op_q;
            end
            S_LOAD_B: begin
                alu_num = b_q;
                alu_en2 = 1'b1;
                alu_op  = op_q;
            end
            S_EXEC: begin
                alu_out_en = 1'b1;
                alu_op     = op_q;
            end
            S_RESP:  rsp_valid = 1'b1;
            default: rsp_valid = 1'b0;
        endcase
    end

    assign cmd_ready = ready_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller directly upstream of the 16-bit ALU. It accepts one operation per valid/ready handshake (opcode plus two operands) and generates the ALU's operand-load timing on the shared `num` bus: the `enin1` and `enin2` load strobes, `opCode` and `outEn`. It captures the ALU `result` into a registered response, which it holds until the consumer accepts it. It replaces the hand-timed strobe sequences currently used to exercise the ALU.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; must match the ALU.
- `OPW`, 3, opcode width.
- `MAX_OP`, 6, highest legal opcode; opcodes above it are rejected.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  OPW  ALU opcode.
- `cmd_a`  in  WIDTH  operand 1.
- `cmd_b`  in  WIDTH  operand 2.
- `cmd_keep_b`  in  1  reuse the operand 2 already in the ALU; skip the B load.
- `alu_num`  out  WIDTH  shared operand bus to the ALU `num` input.
- `alu_en1`  out  1  operand-1 load strobe (ALU `enin1`).
- `alu_en2`  out  1  operand-2 load strobe (ALU `enin2`).
- `alu_op`  out  OPW  opcode to the ALU.
- `alu_out_en`  out  1  ALU output enable (`outEn`).
- `alu_result`  in  WIDTH  ALU result.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  WIDTH  captured result.
- `rsp_err`  out  1  command rejected (illegal opcode); qualified by `rsp_valid`.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch op, a, b and keep_b into internal registers (the handshake completes).
  - If op > MAX_OP, go to RESP with `rsp_err`=1 and `rsp_data`=0. No ALU strobes are issued.
  - Otherwise go to LOAD_A.
- LOAD_A: `alu_num`=a, `alu_en1`=1. Next state is LOAD_B, or EXEC when keep_b=1 and `b_loaded`=1.
- LOAD_B: `alu_num`=b, `alu_en2`=1, then set `b_loaded`. Next state is EXEC.
- EXEC: `alu_out_en`=1 and `alu_op`=op. `alu_result` is captured into `rsp_data` on the edge that leaves EXEC. Next state is RESP with `rsp_err`=0.
- RESP: `rsp_valid`=1, and `rsp_data`/`rsp_err` are held stable. On `rsp_ready`, go to IDLE.
- `b_loaded` rules:
  - Cleared by reset.
  - Set after any LOAD_B.
  - A keep_b command issued while `b_loaded`=0 performs LOAD_B anyway.
- `alu_op` holds the latched opcode from LOAD_A through EXEC and is 0 elsewhere.
- `alu_num` is 0 whenever neither load strobe is asserted.
- At most one of `alu_en1`, `alu_en2`, `alu_out_en` is high in any cycle.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from any cmd_* or rsp_ready input to any output, except that `cmd_ready` depends on state only.
- Latency, counted from the handshake edge to the first `rsp_valid` cycle:
  - 4 cycles for a normal command.
  - 3 cycles with keep_b and `b_loaded`=1.
  - 1 cycle for an illegal opcode.
- Each strobe is high for exactly one cycle, with `alu_num` stable for that whole cycle.
- `rsp_valid` held without `rsp_ready` holds everything. `cmd_ready` stays 0 until the cycle after the response handshake. Throughput is therefore at most one command per 5 cycles (4 with keep_b).
- A `cmd_valid` arriving during a non-IDLE state is ignored and not lost. Since `cmd_ready`=0, the source must hold it.
- `rst` high at any edge, including mid-sequence:
  - Next state IDLE.
  - All outputs 0 (`cmd_ready`=0 during reset, 1 the first cycle after).
  - `b_loaded`=0.
  - Any in-flight command is discarded with no response.
- Reset values: `alu_num`=0, `alu_en1`=0, `alu_en2`=0, `alu_op`=0, `alu_out_en`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0.

## Test plan
- Reset, then op=0, a=256, b=255 -> en1 with num=256, en2 with num=255, then out_en with op=0; `rsp_valid` 4 cycles after the handshake; `rsp_data` equals the ALU result for op 0.
- Opcodes 0..6 back-to-back with a=256+k, keep_b=1, b=255 -> after the first command, no `alu_en2` pulses; 3-cycle latency each; `alu_op` matches k during EXEC.
- keep_b=1 as the first command after reset -> LOAD_B still executes (en2 pulses); latency is 4.
- op=7 -> no strobes; `rsp_valid` after 1 cycle with `rsp_err`=1, `rsp_data`=0.
- Hold `rsp_ready`=0 for 10 cycles with `cmd_valid` held -> `rsp_data` stable, `cmd_ready`=0, no strobes; release -> the next command is accepted the following cycle.
- Assert `rst` during LOAD_B -> all outputs 0 the next cycle, no response; a following keep_b command performs LOAD_B.
